// File: rtl/bru_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bru_pkg
//  Description : Shared definitions for the branch resolve unit: default
//                geometry, prediction-entry layout helpers and the 2-bit
//                predictor state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package bru_pkg;

    localparam int BRU_ADDR_W = 10;
    localparam int BRU_DEPTH  = 4;

    localparam logic [1:0] STATE_SNT = 2'b00;
    localparam logic [1:0] STATE_WNT = 2'b01;
    localparam logic [1:0] STATE_WT  = 2'b10;
    localparam logic [1:0] STATE_ST  = 2'b11;

    // Entry is packed MSB-first as {pc_4, target, state}.
    function automatic int entry_w(input int addr_w);
        return 2 * addr_w + 2;
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic pred_taken(input logic [1:0] state);
        return state[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bru_pred_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bru_pred_fifo
//  Description : In-order circular buffer of outstanding predictions with
//                push, pop and whole-queue clear (clear wins over both).
//  Revision    : 1.0 - initial release
// ============================================================================
module bru_pred_fifo
    import bru_pkg::*;
#(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4,
    localparam int PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] c_full_cnt = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign full      = (r_count == c_full_cnt);
    assign empty     = (r_count == '0);
    assign w_push    = push & ~full;
    assign w_pop     = pop & ~empty;
    assign head_data = r_mem[r_rd_ptr];

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !clear) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit
//  Description : Queues fetch-time predictions, compares them with EX outcomes
//                and emits registered BHT update / mispredict redirect strobes.
//                Define BRU_STATS_EN to add branch and mispredict counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int ADDR_W = BRU_ADDR_W,
    parameter int DEPTH  = BRU_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_valid,
    output logic              pred_ready,
    input  logic [ADDR_W-1:0] pred_pc_4,
    input  logic [ADDR_W-1:0] pred_target,
    input  logic [1:0]        pred_state,
    input  logic              res_valid,
    input  logic              res_taken,
    input  logic [ADDR_W-1:0] res_target,
    input  logic              flush,
    output logic              update_en,
    output logic [ADDR_W-1:0] update_pc_4,
    output logic [ADDR_W-1:0] update_pc_remote,
    output logic [1:0]        update_state_old,
    output logic              branch_succ,
    output logic              redirect_en,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              err_underflow
`ifdef BRU_STATS_EN
    ,
    output logic [15:0]       stat_branches,
    output logic [15:0]       stat_mispred
`endif
);

    localparam int c_entry_w = entry_w(ADDR_W);

    logic [c_entry_w-1:0] w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [ADDR_W-1:0]    w_head_pc_4;
    logic [ADDR_W-1:0]    w_head_target;
    logic [1:0]           w_head_state;
    logic                 w_resolve;
    logic                 w_mispred;

    logic                 r_update_en;
    logic [ADDR_W-1:0]    r_update_pc_4;
    logic [ADDR_W-1:0]    r_update_pc_remote;
    logic [1:0]           r_update_state_old;
    logic                 r_branch_succ;
    logic                 r_redirect_en;
    logic [ADDR_W-1:0]    r_redirect_pc;
    logic                 r_err_underflow;

    assign w_head_pc_4   = w_head[c_entry_w-1 -: ADDR_W];
    assign w_head_target = w_head[ADDR_W+1 -: ADDR_W];
    assign w_head_state  = w_head[1:0];

    // A flush squashes any same-cycle resolution along with the queue.
    assign w_resolve = res_valid & ~w_empty & ~flush;
    assign w_mispred = (res_taken != pred_taken(w_head_state)) |
                       (res_taken & (res_target != w_head_target));

    bru_pred_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pred_valid & ~w_full),
        .push_data ({pred_pc_4, pred_target, pred_state}),
        .pop       (w_resolve),
        .clear     (flush | (w_resolve & w_mispred)),
        .head_data (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_update_en        <= 1'b0;
            r_update_pc_4      <= '0;
            r_update_pc_remote <= '0;
            r_update_state_old <= '0;
            r_branch_succ      <= 1'b0;
            r_redirect_en      <= 1'b0;
            r_redirect_pc      <= '0;
            r_err_underflow    <= 1'b0;
        end else begin
            r_update_en   <= w_resolve;
            r_redirect_en <= w_resolve & w_mispred;
            if (w_resolve) begin
                r_update_pc_4      <= w_head_pc_4;
                r_update_pc_remote <= res_taken ? res_target : w_head_target;
                r_update_state_old <= w_head_state;
                r_branch_succ      <= res_taken;
                r_redirect_pc      <= res_taken ? res_target : w_head_pc_4;
            end
            if (res_valid && w_empty) r_err_underflow <= 1'b1;
        end
    end

    assign pred_ready       = ~w_full;
    assign update_en        = r_update_en;
    assign update_pc_4      = r_update_pc_4;
    assign update_pc_remote = r_update_pc_remote;
    assign update_state_old = r_update_state_old;
    assign branch_succ      = r_branch_succ;
    assign redirect_en      = r_redirect_en;
    assign redirect_pc      = r_redirect_pc;
    assign err_underflow    = r_err_underflow;

`ifdef BRU_STATS_EN
    logic [15:0] r_stat_branches;
    logic [15:0] r_stat_mispred;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_branches <= '0;
            r_stat_mispred  <= '0;
        end else begin
            if (w_resolve && (r_stat_branches != 16'hFFFF))
                r_stat_branches <= r_stat_branches + 16'd1;
            if (w_resolve && w_mispred && (r_stat_mispred != 16'hFFFF))
                r_stat_mispred <= r_stat_mispred + 16'd1;
        end
    end

    assign stat_branches = r_stat_branches;
    assign stat_mispred  = r_stat_mispred;
`endif

endmodule
`default_nettype wire
